// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-outstanding load/store sequencer for the memory-mapped
// register block. Drives the active-low Mem_rd/Mem_wr strobes with the
// address and data held one cycle either side of the strobe, and returns one
// response per request with an error flag for unmapped or misaligned addresses.
module mem_bus_ctrl #(
   parameter logic [31:0] ADDR_BASE     = 32'h1000_0000,
   parameter int unsigned NUM_REGS      = 3,
   parameter int unsigned STROBE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        Mem_rd,
   output logic        Mem_wr,
   output logic [31:0] Dir_Mem,
   output logic [31:0] Dato_Mem_in,
   input  logic [31:0] Dato_Mem_out
);

   localparam int unsigned      CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STROBE_CYCLES - 1);
   // 33-bit bounds so the upper limit can never wrap past 2^32
   localparam logic [32:0]      ADDR_LO  = {1'b0, ADDR_BASE};
   localparam logic [32:0]      ADDR_HI  = ADDR_LO + 33'(4 * (NUM_REGS - 1));

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_RESP
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             wr_q;
   logic             err_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;

   logic             mem_rd_q;
   logic             mem_wr_q;
   logic [31:0]      dir_q;
   logic [31:0]      dato_in_q;
   logic             resp_valid_q;
   logic [31:0]      resp_rdata_q;
   logic             resp_err_q;

   logic             addr_ok_c;

   // Word-aligned and inside the register window
   assign addr_ok_c = (req_addr[1:0] == 2'b00) &&
                      ({1'b0, req_addr} >= ADDR_LO) &&
                      ({1'b0, req_addr} <= ADDR_HI);

   assign req_ready   = (state_q == S_IDLE) && !rst;
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_err    = resp_err_q;
   assign Mem_rd      = mem_rd_q;
   assign Mem_wr      = mem_wr_q;
   assign Dir_Mem     = dir_q;
   assign Dato_Mem_in = dato_in_q;

   // Sequencer and pin registers. The pins are decoded from the state a cycle
   // earlier, so the memory-facing phases (setup, strobe, hold, response)
   // appear at the outputs one cycle after the state enters them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         wr_q         <= 1'b0;
         err_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mem_rd_q     <= 1'b1;
         mem_wr_q     <= 1'b1;
         dir_q        <= '0;
         dato_in_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         // Only one strobe can be low, and only while the state is STROBE
         mem_rd_q <= !((state_q == S_STROBE) && !wr_q);
         mem_wr_q <= !((state_q == S_STROBE) &&  wr_q);

         if (state_q == S_SETUP) begin
            dir_q     <= addr_q;
            dato_in_q <= wr_q ? wdata_q : '0;
         end

         // The strobe rises on this edge, so read data is still driven
         if (state_q == S_HOLD) begin
            resp_rdata_q <= wr_q ? '0 : Dato_Mem_out;
         end

         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  wr_q    <= req_wr;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  err_q   <= !addr_ok_c;
                  state_q <= addr_ok_c ? S_SETUP : S_RESP;
               end
            end
            S_SETUP: begin
               cnt_q   <= CNT_INIT;
               state_q <= S_STROBE;
            end
            S_STROBE: begin
               if (cnt_q == '0) begin
                  state_q <= S_HOLD;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_HOLD: begin
               state_q <= S_RESP;
            end
            S_RESP: begin
               if (!resp_valid_q) begin
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= err_q;
                  if (err_q) begin
                     resp_rdata_q <= '0;
                  end
               end else if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Request-side bus controller that sits directly upstream of the memory-mapped register block at 0x10000000–0x10000008. It accepts single load/store requests from the processor memory stage over a valid/ready handshake and sequences the memory's active-low `Mem_rd`/`Mem_wr` strobes, `Dir_Mem` address and `Dato_Mem_in` write data. It captures `Dato_Mem_out` and returns a response with an error flag for illegal addresses. Exactly one transaction is in flight at a time.

## Interface
- `ADDR_BASE`, 32'h10000000, address of register 0.
- `NUM_REGS`, 3, number of 32-bit word registers mapped at `ADDR_BASE + 4*i`.
- `STROBE_CYCLES`, 2, clock cycles the strobe is held low; legal range 1–15.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; a request is accepted on an edge where `req_valid && req_ready`.
- `req_wr` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts response.
- `resp_rdata` out 32: load data; 0 for stores and errors.
- `resp_err` out 1: 1 = address misaligned or outside the map.
- `Mem_rd` out 1: active-low read strobe to memory.
- `Mem_wr` out 1: active-low write strobe to memory.
- `Dir_Mem` out 32: memory address.
- `Dato_Mem_in` out 32: write data to memory.
- `Dato_Mem_out` in 32: read data from memory.

## Operation
- All outputs are registered except `req_ready`, which is `(state==IDLE) && !rst`.
- Reset values: `Mem_rd`=1, `Mem_wr`=1, `Dir_Mem`=0, `Dato_Mem_in`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, state=IDLE, strobe counter=0.
- Address legality: a request is legal iff `req_addr[1:0]==0` and `ADDR_BASE <= req_addr <= ADDR_BASE + 4*(NUM_REGS-1)`. The comparison is a full 32-bit unsigned compare with no wrap.
- **IDLE:**
  - On accept, latch `req_wr`, `req_addr` and `req_wdata`.
  - Legal request → SETUP.
  - Illegal request → RESP with `resp_err`=1 and `resp_rdata`=0. No strobe is issued and `Dir_Mem` is unchanged.
- **SETUP** (1 cycle):
  - `Dir_Mem` = latched address.
  - `Dato_Mem_in` = latched wdata for stores, 0 for loads.
  - Both strobes stay 1.
- **STROBE** (`STROBE_CYCLES` cycles):
  - Exactly one strobe is low: `Mem_rd`=0 for loads, `Mem_wr`=0 for stores.
  - Both strobes are never low together.
  - A down-counter is loaded with `STROBE_CYCLES-1` on entry.
  - For loads, `Dato_Mem_out` is captured into `resp_rdata` on the edge that leaves STROBE.
- **HOLD** (1 cycle): both strobes are 1. `Dir_Mem` and `Dato_Mem_in` are held, so the address never changes while a strobe is low.
- **RESP:**
  - `resp_valid`=1.
  - `resp_err`=0 for legal transactions.
  - `resp_rdata` = captured data for loads, 0 for stores.
  - Response outputs stay stable until `resp_valid && resp_ready` on an edge; then `resp_valid` goes to 0 and the state returns to IDLE.
- `Dir_Mem`/`Dato_Mem_in` keep their last values in IDLE and RESP; the strobes are high there, so the memory is inert.
- **Reset mid-operation:** on the next edge with `rst`=1, go to IDLE and apply all reset values, including strobes to 1. The in-flight transaction is dropped and no response is produced.
- New requests are not accepted in RESP, even when `resp_ready`=1 on the same edge. The earliest next accept is the edge after returning to IDLE.

## Timing
- Cycle numbering: edge E0 accepts the request; cycle k is the interval following edge Ek.
- Legal transaction:
  - SETUP in cycle 1.
  - Strobe low in cycles 2 … `STROBE_CYCLES`+1.
  - HOLD in cycle `STROBE_CYCLES`+2.
  - `resp_valid` high from cycle `STROBE_CYCLES`+3.
  - Default: strobe low in cycles 2–3 and response in cycle 5.
- Illegal transaction: `resp_valid` high in cycle 1.
- Throughput with `resp_ready` held at 1: one legal transaction per `STROBE_CYCLES`+5 cycles (7 with default parameters).
- Address and write data are stable from SETUP through HOLD, one cycle either side of the strobe. This covers both clock phases of the memory's level-sensitive logic.

## Test plan
- Reset, then store 0xDEADBEEF to 0x10000004 → `Mem_wr` low for exactly cycles 2–3, `Mem_rd`=1 throughout, `Dir_Mem`=0x10000004 cycles 1–4, `resp_valid` in cycle 5 with `resp_err`=0 and `resp_rdata`=0. A following load of 0x10000004 returns 0xDEADBEEF.
- Load 0x10000000 after reset → `resp_rdata`=0x00000000, `resp_err`=0. Store 0x12345678 to 0x10000008, then load it back → 0x12345678. Register 0x10000000 is still 0.
- Illegal addresses 0x10000002, 0x1000000C and 0x0FFFFFFC → `resp_valid` in cycle 1, `resp_err`=1, `resp_rdata`=0, both strobes never low.
- Backpressure: hold `resp_ready`=0 for 10 cycles after a load → `resp_valid` and `resp_rdata` stable, `req_ready`=0, no strobe activity. Release → one handshake, then back to IDLE.
- Assert `rst` during cycle 2 of a store → strobes return to 1 on the next edge, no response is produced, and `req_ready`=1 after `rst` is deasserted.
- Set `STROBE_CYCLES`=1 and `STROBE_CYCLES`=4 → strobe low for exactly 1 and 4 cycles, response in cycles 4 and 7, read data is correct in both.
